// File: rtl/fp_normalize_round.sv
`default_nettype none
// ============================================================================
//  Module      : fp_normalize_round
//  Description : Two-stage normalise-and-round back end for the FP multiplier.
//                Stage 1 picks the 1.x or 2.x product alignment and extracts
//                mantissa, guard and sticky bits. Stage 2 applies one of four
//                rounding modes, checks the exponent range and packs the
//                result. Valid/ready flow control runs on both stages.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                in_valid/in_ready  - input handshake
//                in_sign, in_exp,
//                in_prod, in_rmode  - product sign, signed biased exponent
//                                     sum, raw mantissa product, round mode
//                out_valid/out_ready- output handshake
//                out_result         - {sign, exponent, fraction}
//                out_overflow,
//                out_underflow,
//                out_inexact        - flags aligned with out_result
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_normalize_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W+1:0]       in_exp,
    input  logic [2*MAN_W+1:0]     in_prod,
    input  logic [1:0]             in_rmode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_overflow,
    output logic                   out_underflow,
    output logic                   out_inexact
);

    localparam int c_PW  = 2*MAN_W + 2;     // product width
    localparam int c_EW  = EXP_W + 2;       // internal signed exponent width
    localparam int c_RW  = 1 + EXP_W + MAN_W;

    localparam logic [1:0] c_RNE = 2'b00;
    localparam logic [1:0] c_RTZ = 2'b01;
    localparam logic [1:0] c_RUP = 2'b10;
    localparam logic [1:0] c_RDN = 2'b11;

    // First exponent value that no longer fits a finite encoding.
    localparam int                     c_EXP_OVF_I = (1 << EXP_W) - 1;
    localparam logic signed [c_EW-1:0] c_EXP_OVF   = c_EXP_OVF_I[c_EW-1:0];

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic              r_s1_valid_q,  w_s1_valid_d;
    logic [MAN_W-1:0]  r_s1_man_q,    w_s1_man_d;
    logic              r_s1_guard_q,  w_s1_guard_d;
    logic              r_s1_sticky_q, w_s1_sticky_d;
    logic [c_EW-1:0]   r_s1_exp_q,    w_s1_exp_d;
    logic              r_s1_sign_q,   w_s1_sign_d;
    logic [1:0]        r_s1_rmode_q,  w_s1_rmode_d;
    logic              r_s1_zero_q,   w_s1_zero_d;

    logic              r_s2_valid_q,  w_s2_valid_d;
    logic [c_RW-1:0]   r_s2_res_q,    w_s2_res_d;
    logic              r_s2_ovf_q,    w_s2_ovf_d;
    logic              r_s2_unf_q,    w_s2_unf_d;
    logic              r_s2_inx_q,    w_s2_inx_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic w_s1_adv;

    assign w_s2_adv = !r_s2_valid_q || out_ready;
    assign w_s1_adv = !r_s1_valid_q || w_s2_adv;
    assign in_ready = w_s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: normalise
    // ------------------------------------------------------------------
    logic             w_top;
    logic [MAN_W-1:0] w_n_man;
    logic             w_n_guard;
    logic             w_n_sticky;
    logic [c_EW-1:0]  w_n_exp;

    // A product in [2,4) has its leading one at the MSB and needs one extra
    // right shift, which is absorbed by bumping the exponent.
    assign w_top      = in_prod[c_PW-1];
    assign w_n_man    = w_top ? in_prod[2*MAN_W:MAN_W+1] : in_prod[2*MAN_W-1:MAN_W];
    assign w_n_guard  = w_top ? in_prod[MAN_W]           : in_prod[MAN_W-1];
    assign w_n_sticky = w_top ? (|in_prod[MAN_W-1:0])    : (|in_prod[MAN_W-2:0]);
    assign w_n_exp    = in_exp + {{(c_EW-1){1'b0}}, w_top};

    // ------------------------------------------------------------------
    // Stage 2: round and range check
    // ------------------------------------------------------------------
    logic             w_gs;
    logic             w_incr;
    logic [MAN_W:0]   w_sum;
    logic             w_carry;
    logic [c_EW-1:0]  w_r_exp;
    logic             w_ovf_cond;
    logic             w_unf_cond;
    logic             w_to_inf;
    logic [c_RW-1:0]  w_r_res;
    logic             w_r_ovf;
    logic             w_r_unf;
    logic             w_r_inx;

    assign w_gs = r_s1_guard_q || r_s1_sticky_q;

    always_comb begin
        w_incr = 1'b0;
        case (r_s1_rmode_q)
            c_RNE:   w_incr = r_s1_guard_q && (r_s1_sticky_q || r_s1_man_q[0]);
            c_RTZ:   w_incr = 1'b0;
            c_RUP:   w_incr = !r_s1_sign_q && w_gs;
            c_RDN:   w_incr = r_s1_sign_q && w_gs;
            default: w_incr = 1'b0;
        endcase
    end

    // On a carry out the low MAN_W bits of the sum are already zero, so the
    // fraction field needs no separate clearing.
    assign w_sum    = {1'b0, r_s1_man_q} + {{MAN_W{1'b0}}, w_incr};
    assign w_carry  = w_sum[MAN_W];
    assign w_r_exp  = r_s1_exp_q + {{(c_EW-1){1'b0}}, w_carry};

    // Range checks use the full signed width so wrapped values never alias
    // into the legal exponent range.
    assign w_ovf_cond = $signed(w_r_exp) >= c_EXP_OVF;
    assign w_unf_cond = w_r_exp[c_EW-1] || (w_r_exp == '0);

    // Overflow saturates to infinity only when rounding moves toward the
    // infinity of the result's sign.
    assign w_to_inf = (r_s1_rmode_q == c_RNE)
                   || ((r_s1_rmode_q == c_RUP) && !r_s1_sign_q)
                   || ((r_s1_rmode_q == c_RDN) &&  r_s1_sign_q);

    always_comb begin
        w_r_res = {r_s1_sign_q, w_r_exp[EXP_W-1:0], w_sum[MAN_W-1:0]};
        w_r_ovf = 1'b0;
        w_r_unf = 1'b0;
        w_r_inx = w_gs;
        // An exact zero product is zero regardless of its exponent.
        if (r_s1_zero_q) begin
            w_r_res = {r_s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
            w_r_inx = 1'b0;
        end else if (w_ovf_cond) begin
            w_r_ovf = 1'b1;
            w_r_inx = 1'b1;
            if (w_to_inf) begin
                w_r_res = {r_s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                w_r_res = {r_s1_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end
        end else if (w_unf_cond) begin
            // No subnormal encodings: tiny results flush to signed zero.
            w_r_unf = 1'b1;
            w_r_inx = 1'b1;
            w_r_res = {r_s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_s1_valid_d  = r_s1_valid_q;
        w_s1_man_d    = r_s1_man_q;
        w_s1_guard_d  = r_s1_guard_q;
        w_s1_sticky_d = r_s1_sticky_q;
        w_s1_exp_d    = r_s1_exp_q;
        w_s1_sign_d   = r_s1_sign_q;
        w_s1_rmode_d  = r_s1_rmode_q;
        w_s1_zero_d   = r_s1_zero_q;
        w_s2_valid_d  = r_s2_valid_q;
        w_s2_res_d    = r_s2_res_q;
        w_s2_ovf_d    = r_s2_ovf_q;
        w_s2_unf_d    = r_s2_unf_q;
        w_s2_inx_d    = r_s2_inx_q;

        // Output registers only load real beats, so they hold steady across
        // stalls and bubbles.
        if (w_s2_adv) begin
            w_s2_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_s2_res_d = w_r_res;
                w_s2_ovf_d = w_r_ovf;
                w_s2_unf_d = w_r_unf;
                w_s2_inx_d = w_r_inx;
            end
        end

        if (w_s1_adv) begin
            w_s1_valid_d = in_valid;
            if (in_valid) begin
                w_s1_man_d    = w_n_man;
                w_s1_guard_d  = w_n_guard;
                w_s1_sticky_d = w_n_sticky;
                w_s1_exp_d    = w_n_exp;
                w_s1_sign_d   = in_sign;
                w_s1_rmode_d  = in_rmode;
                w_s1_zero_d   = ~|in_prod;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid_q  <= 1'b0;
            r_s1_man_q    <= '0;
            r_s1_guard_q  <= 1'b0;
            r_s1_sticky_q <= 1'b0;
            r_s1_exp_q    <= '0;
            r_s1_sign_q   <= 1'b0;
            r_s1_rmode_q  <= 2'b00;
            r_s1_zero_q   <= 1'b0;
            r_s2_valid_q  <= 1'b0;
            r_s2_res_q    <= '0;
            r_s2_ovf_q    <= 1'b0;
            r_s2_unf_q    <= 1'b0;
            r_s2_inx_q    <= 1'b0;
        end else begin
            r_s1_valid_q  <= w_s1_valid_d;
            r_s1_man_q    <= w_s1_man_d;
            r_s1_guard_q  <= w_s1_guard_d;
            r_s1_sticky_q <= w_s1_sticky_d;
            r_s1_exp_q    <= w_s1_exp_d;
            r_s1_sign_q   <= w_s1_sign_d;
            r_s1_rmode_q  <= w_s1_rmode_d;
            r_s1_zero_q   <= w_s1_zero_d;
            r_s2_valid_q  <= w_s2_valid_d;
            r_s2_res_q    <= w_s2_res_d;
            r_s2_ovf_q    <= w_s2_ovf_d;
            r_s2_unf_q    <= w_s2_unf_d;
            r_s2_inx_q    <= w_s2_inx_d;
        end
    end

    assign out_valid     = r_s2_valid_q;
    assign out_result    = r_s2_res_q;
    assign out_overflow  = r_s2_ovf_q;
    assign out_underflow = r_s2_unf_q;
    assign out_inexact   = r_s2_inx_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_round.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_normalize_round
//  Description : Self-checking bench for fp_normalize_round (EXP_W=8,
//                MAN_W=23) with an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_round;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_prod = '0;
    logic [1:0]  in_rmode = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_normalize_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_prod       (in_prod),
        .in_rmode      (in_rmode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    // Reference: the product is a fixed-point value with 46 fraction bits.
    // Drop `sh` bits, then decide rounding by comparing the discarded
    // remainder against one half ulp. Returns {ovf, unf, inx, result}.
    function automatic logic [34:0] model(input logic s, input logic [9:0] ex,
                                          input logic [47:0] p, input logic [1:0] rm);
        longint unsigned pv, kept, rem, half, frac;
        int              sh, e;
        bit              up, nz;
        if (p == 48'd0) return {3'b000, s, 31'd0};
        pv   = 64'(p);
        sh   = p[47] ? 24 : 23;
        kept = pv >> sh;
        rem  = pv & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        e    = int'($signed(ex)) + (p[47] ? 1 : 0);
        nz   = (rem != 0);
        case (rm)
            2'b00:   up = (rem > half) || ((rem == half) && (kept % 2 == 1));
            2'b01:   up = 1'b0;
            2'b10:   up = !s && nz;
            default: up = s && nz;
        endcase
        frac = (kept % (64'd1 << 23)) + (up ? 64'd1 : 64'd0);
        if (frac == (64'd1 << 23)) begin
            frac = 0;
            e    = e + 1;
        end
        if (e >= 255) begin
            if (rm == 2'b00 || (rm == 2'b10 && !s) || (rm == 2'b11 && s))
                return {3'b101, s, 8'hFF, 23'h000000};
            return {3'b101, s, 8'hFE, 23'h7FFFFF};
        end
        if (e <= 0) return {3'b011, s, 31'd0};
        return {2'b00, nz, s, e[7:0], frac[22:0]};
    endfunction

    function automatic logic [47:0] rand_prod();
        logic [63:0] r;
        logic [47:0] p;
        int          k;
        r = {$urandom, $urandom};
        p = r[47:0];
        k = $urandom_range(0, 7);
        if (k == 0) begin
            p = '0;
        end else if (k <= 3) begin
            p[47] = 1'b1;
        end else if (k <= 6) begin
            p[47] = 1'b0;
            p[46] = 1'b1;
        end else begin
            // Exact ties / carry chains: sticky region cleared.
            p[47]   = 1'b0;
            p[46]   = 1'b1;
            p[21:0] = '0;
            if (r[63]) p[45:23] = '1;
        end
        return p;
    endfunction

    function automatic logic [9:0] rand_exp();
        int e;
        case ($urandom_range(0, 3))
            0:       e = $urandom_range(0, 10) - 5;
            1:       e = $urandom_range(250, 258);
            2:       e = $urandom_range(1, 254);
            default: e = $urandom_range(0, 400) - 50;
        endcase
        return e[9:0];
    endfunction

    task automatic set_beat(input logic s, input logic [9:0] e,
                            input logic [47:0] p, input logic [1:0] rm);
        in_sign  = s;
        in_exp   = e;
        in_prod  = p;
        in_rmode = rm;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({out_overflow, out_underflow, out_inexact, out_result} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_overflow, out_underflow, out_inexact, out_result});
        end
    endtask

    // One isolated beat: checks 2-cycle latency and the packed result.
    task automatic test_single(input string name, input logic s, input logic [9:0] e,
                               input logic [47:0] p, input logic [1:0] rm,
                               input logic [31:0] exp_res, input logic [2:0] exp_flags);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_beat(s, e, p, rm);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_latency1: out_valid %b expected 0", name, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s_latency2: out_valid %b expected 1", name, out_valid);
        end
        n_checks++;
        if ({out_overflow, out_underflow, out_inexact, out_result} !== {exp_flags, exp_res}) begin
            n_fail++;
            $display("FAIL %s: got res %h flags %b expected res %h flags %b", name,
                     out_result, {out_overflow, out_underflow, out_inexact}, exp_res, exp_flags);
        end
    endtask

    task automatic test_directed();
        test_single("norm_shift",   1'b0, 10'd127, 48'h900000000000, 2'b00, 32'h40100000, 3'b000);
        test_single("rne_up",       1'b0, 10'd127, 48'h400000C00000, 2'b00, 32'h3F800002, 3'b001);
        test_single("rtz_trunc",    1'b0, 10'd127, 48'h400000C00000, 2'b01, 32'h3F800001, 3'b001);
        test_single("rne_tie_even", 1'b0, 10'd127, 48'h400000400000, 2'b00, 32'h3F800000, 3'b001);
        test_single("round_carry",  1'b0, 10'd127, 48'h7FFFFFC00000, 2'b00, 32'h40000000, 3'b001);
        test_single("ovf_inf",      1'b0, 10'd254, 48'h800000000000, 2'b00, 32'h7F800000, 3'b101);
        test_single("ovf_maxfin",   1'b0, 10'd254, 48'h800000000000, 2'b01, 32'h7F7FFFFF, 3'b101);
        test_single("underflow",    1'b1, 10'd0,   48'h400000000000, 2'b00, 32'h80000000, 3'b011);
        test_single("zero",         1'b1, 10'd127, 48'h000000000000, 2'b10, 32'h80000000, 3'b000);
    endtask

    // Mode changes on consecutive beats must stay attached to their beat.
    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        set_beat(1'b0, 10'd127, 48'h400000C00000, 2'b00);
        @(negedge clk);
        set_beat(1'b0, 10'd127, 48'h400000C00000, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (!(out_valid === 1'b1 && out_result === 32'h3F800002)) begin
            n_fail++; $display("FAIL b2b_first: valid %b res %h expected 1 3f800002", out_valid, out_result);
        end
        @(negedge clk);
        n_checks++;
        if (!(out_valid === 1'b1 && out_result === 32'h3F800001)) begin
            n_fail++; $display("FAIL b2b_second: valid %b res %h expected 1 3f800001", out_valid, out_result);
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic [34:0] expq[$];
        logic [34:0] held, exp_v;
        logic        bs[4];
        logic [9:0]  be[4];
        logic [47:0] bp[4];
        logic [1:0]  bm[4];
        bit          stalled = 0;
        int          acc = 0, got = 0;
        for (int i = 0; i < 4; i++) begin
            bs[i] = 1'($urandom); be[i] = 10'($urandom_range(20, 200));
            bp[i] = rand_prod();  bm[i] = 2'($urandom);
        end
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc < 5);
            in_valid  = (acc < 4);
            if (acc < 4) set_beat(bs[acc], be[acc], bp[acc], bm[acc]);
            #1;
            if (cyc == 2) begin
                n_checks++;
                if (!(in_ready === 1'b0 && acc == 2)) begin
                    n_fail++; $display("FAIL bp_in_ready_low: in_ready %b accepted %0d expected 0 and 2", in_ready, acc);
                end
            end
            if (stalled) begin
                n_checks++;
                if ({out_overflow, out_underflow, out_inexact, out_result} !== held) begin
                    n_fail++; $display("FAIL bp_hold: got %h expected %h",
                                       {out_overflow, out_underflow, out_inexact, out_result}, held);
                end
            end
            if (out_valid && out_ready) begin
                exp_v = (expq.size() > 0) ? expq.pop_front() : 35'h7FFFFFFFF;
                n_checks++;
                if ({out_overflow, out_underflow, out_inexact, out_result} !== exp_v) begin
                    n_fail++; $display("FAIL bp_result%0d: got %h expected %h", got,
                                       {out_overflow, out_underflow, out_inexact, out_result}, exp_v);
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_overflow, out_underflow, out_inexact, out_result};
            if (in_valid && in_ready) begin
                expq.push_back(model(bs[acc], be[acc], bp[acc], bm[acc]));
                acc++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 4 || expq.size() != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d results (%0d pending) expected 4", got, expq.size());
        end
    endtask

    task automatic test_random();
        logic [34:0] expq[$];
        logic [34:0] held, exp_v;
        bit          stalled = 0;
        int          emitted = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            if (cyc < 400) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 7);
                set_beat(1'($urandom), rand_exp(), rand_prod(), 2'($urandom));
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (stalled) begin
                n_checks++;
                if ({out_overflow, out_underflow, out_inexact, out_result} !== held) begin
                    n_fail++; $display("FAIL rand_hold: got %h expected %h",
                                       {out_overflow, out_underflow, out_inexact, out_result}, held);
                end
            end
            if (out_valid && out_ready) begin
                exp_v = (expq.size() > 0) ? expq.pop_front() : 35'h7FFFFFFFF;
                n_checks++;
                if ({out_overflow, out_underflow, out_inexact, out_result} !== exp_v) begin
                    n_fail++; $display("FAIL rand_result%0d: got %h expected %h", emitted,
                                       {out_overflow, out_underflow, out_inexact, out_result}, exp_v);
                end
                emitted++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_overflow, out_underflow, out_inexact, out_result};
            if (in_valid && in_ready)
                expq.push_back(model(in_sign, in_exp, in_prod, in_rmode));
        end
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: %0d results pending expected 0", expq.size());
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        set_beat(1'b0, 10'd127, 48'h900000000000, 2'b00);
        @(negedge clk);
        set_beat(1'b1, 10'd100, 48'h400000C00000, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (!(out_valid === 1'b1 && in_ready === 1'b0)) begin
            n_fail++; $display("FAIL mid_full: out_valid %b in_ready %b expected 1 0", out_valid, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (!(out_valid === 1'b0 && in_ready === 1'b1)) begin
            n_fail++; $display("FAIL mid_reset: out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
        end
        n_checks++;
        if ({out_overflow, out_underflow, out_inexact, out_result} !== 35'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0",
                               {out_overflow, out_underflow, out_inexact, out_result});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL mid_discard: %0d stale beats emitted expected 0", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_back_pressure();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_normalize_round.md
# fp_normalize_round

Pipelined, parametrised normalise-and-round stage for the floating-point multiplier datapath. It takes the raw double-width mantissa product, the pre-normalisation biased exponent and the sign. It returns a packed IEEE-754-style result with overflow, underflow and inexact flags. It adds four rounding modes, valid/ready flow control and exponent range checking, and sits between the mantissa multiplier array and the result register.

## Interface
Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width; the hidden bit is implicit

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_sign  in  1  product sign
- in_exp  in  EXP_W+2  signed two's-complement biased exponent sum (ea+eb-bias), before normalisation
- in_prod  in  2*MAN_W+2  unsigned mantissa product; bit 2*MAN_W+1 is the MSB
- in_rmode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_result  out  1+EXP_W+MAN_W  {sign, exponent, fraction}
- out_overflow, out_underflow, out_inexact  out  1 each  flags aligned with out_result

## Operation
- Stage 1 (normalise):
  - If prod[2*MAN_W+1]=1: the mantissa is prod[2*MAN_W:MAN_W+1], guard is prod[MAN_W], sticky is OR of prod[MAN_W-1:0], and e = in_exp+1.
  - Otherwise: the mantissa is prod[2*MAN_W-1:MAN_W], guard is prod[MAN_W-1], sticky is OR of prod[MAN_W-2:0], and e = in_exp.
  - zero = (prod==0).
  - Register mantissa, guard, sticky, e, sign, rmode and zero.
- Stage 2 (round and check):
  - Increment condition by mode:
    - RNE: guard & (sticky | lsb).
    - RTZ: never.
    - RUP: !sign & (guard|sticky).
    - RDN: sign & (guard|sticky).
  - inexact_r = guard|sticky.
  - If the increment carries out of MAN_W bits, the fraction becomes 0 and e becomes e+1.
  - Overflow when e >= 2^EXP_W-1:
    - Set out_overflow=1 and out_inexact=1.
    - If the mode rounds away toward that sign's infinity (RNE; RUP with sign 0; RDN with sign 1), the result is ±inf: exponent all ones, fraction 0.
    - Otherwise the result is the max finite value: exponent 2^EXP_W-2, fraction all ones.
  - Underflow when e <= 0 and !zero:
    - Result is signed zero.
    - Set out_underflow=1 and out_inexact=1.
    - Subnormals are not produced (flush to zero).
  - zero: result is signed zero with all flags 0.
  - Otherwise: result is {sign, e[EXP_W-1:0], fraction}; out_inexact = inexact_r; overflow and underflow are 0.
- Checks use the full EXP_W+2-bit signed e; there is no truncation before comparison.

## Timing
- Reset: on a clk edge with rst=1, both stage valids clear.
  - Next cycle: out_valid=0 and in_ready=1.
  - out_result and all flags read 0.
  - An in-flight beat is discarded, never emitted.
- Latency: 2 cycles from an accepted input (in_valid & in_ready) to out_valid, with no stalls. Throughput is 1 beat per cycle.
- Handshake:
  - Stage 2 advances when !s2_valid | out_ready.
  - Stage 1 advances when !s1_valid | stage-2 advance.
  - in_ready = stage-1 advance, a combinational function of the valid registers and out_ready.
  - out_result and the flags hold stable while out_valid & !out_ready.
  - A transfer occurs only on valid & ready in the same cycle.
  - Accept and emit in the same cycle are legal when full.
- Stall: with both stages full and out_ready=0, in_ready=0 and no state changes.
- Bubbles: in_valid=0 advances an empty slot; out_valid drops accordingly.
- in_rmode is sampled with the beat and travels with it; a mode change mid-stream affects only later beats.

## Test plan
All cases use EXP_W=8, MAN_W=23, 48-bit product.
- Normalise shift: prod=0x900000000000, exp=127, sign 0, RNE -> out_result 0x40100000 (2.25), flags 0, out_valid two cycles after accept.
- Ties and modes, exp=127:
  - prod=0x400000C00000 RNE -> 0x3F800002, inexact 1.
  - Same prod in RTZ -> 0x3F800001.
  - prod=0x400000400000 RNE -> 0x3F800000, inexact 1.
- Round carry: prod=0x7FFFFFC00000, exp=127, RNE -> 0x40000000, inexact 1.
- Range checks:
  - prod=0x800000000000, exp=254, RNE -> 0x7F800000 with overflow=1, inexact=1.
  - Same beat in RTZ -> 0x7F7FFFFF.
  - prod=0x400000000000, exp=0, sign 1 -> 0x80000000 with underflow=1.
  - prod=0 -> signed zero, flags 0.
- Back-pressure: stream 4 beats while holding out_ready=0 for 3 cycles.
  - in_ready falls once 2 beats are held.
  - out_result stays stable.
  - All 4 results emerge in order with no loss or duplication.
- Reset mid-flight: assert rst for one cycle with both stages full -> out_valid=0 the next cycle, in_ready=1, the held beats never appear.
